// File: rtl/host_mem_responder.sv
// host_mem_responder: memory-side burst responder for the host read/write protocol, backed by a local word array.
module host_mem_responder #(
  parameter int          DEPTH    = 8192,
  parameter logic [63:0] MEM_BASE = 64'h0,
  parameter int          RD_LAT   = 2,
  parameter int          WR_LAT   = 1,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          read_enable,
  input  logic [63:0]   read_addr,
  input  logic [63:0]   read_size,
  input  logic          finish_read,
  output logic [63:0]   read_ready,
  output logic [31:0]   read_data,
  input  logic          write_enable,
  input  logic [63:0]   write_addr,
  input  logic [31:0]   write_data,
  input  logic [63:0]   write_size,
  input  logic          finish_write,
  output logic [63:0]   write_ready,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic [31:0]   dbg_rdata,
  output logic          err,
  output logic [31:0]   rd_beats,
  output logic [31:0]   wr_beats
);
  localparam int ML = RD_LAT > WR_LAT ? RD_LAT : WR_LAT;
  localparam int CW = $clog2(ML + 1);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, RD_HOLD, WR_WAIT, WR_RESP, WR_HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rd_fire, wr_fire, dbg_fire;
  logic [31:0] mem [DEPTH];
  logic unused_ok;
  assign unused_ok = ^{read_size, write_size};
  function automatic logic ok(input logic [63:0] a);
    return (a >= MEM_BASE) && (((a - MEM_BASE) >> 2) < 64'(DEPTH)) && (a[1:0] == 2'b00);
  endfunction
  function automatic logic [AW-1:0] idx(input logic [63:0] a);
    return AW'((a - MEM_BASE) >> 2);
  endfunction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // HOLD exits on a dropped enable before honouring a same-cycle finish pulse
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = write_enable ? WR_WAIT : read_enable ? RD_WAIT : IDLE;
      RD_WAIT: state_d = !read_enable ? IDLE : cnt_q == '0 ? RD_RESP : RD_WAIT;
      RD_RESP: state_d = RD_HOLD;
      RD_HOLD: state_d = !read_enable ? IDLE : finish_read ? RD_WAIT : RD_HOLD;
      WR_WAIT: state_d = !write_enable ? IDLE : cnt_q == '0 ? WR_RESP : WR_WAIT;
      WR_RESP: state_d = WR_HOLD;
      WR_HOLD: state_d = !write_enable ? IDLE : finish_write ? WR_WAIT : WR_HOLD;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d == RD_WAIT && state_q != RD_WAIT) ? CW'(RD_LAT - 1) :
            (state_d == WR_WAIT && state_q != WR_WAIT) ? CW'(WR_LAT - 1) :
            (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  always_comb begin
    rd_fire     = state_q == RD_WAIT && read_enable && cnt_q == '0;
    wr_fire     = state_q == WR_RESP;
    dbg_fire    = state_q == IDLE && dbg_we;
    read_ready  = {63'd0, state_q == RD_RESP};
    write_ready = {63'd0, wr_fire};
  end
  always_ff @(posedge clk) begin
    if (wr_fire && ok(write_addr)) mem[idx(write_addr)] <= write_data;
    else if (dbg_fire) mem[dbg_addr] <= dbg_wdata;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
      dbg_rdata <= '0;
      err       <= 1'b0;
      rd_beats  <= '0;
      wr_beats  <= '0;
    end else begin
      dbg_rdata <= mem[dbg_addr];
      if (rd_fire) read_data <= ok(read_addr) ? mem[idx(read_addr)] : ERR_DATA;
      if ((rd_fire && !ok(read_addr)) || (wr_fire && !ok(write_addr))) err <= 1'b1;
      if (state_q == RD_RESP) rd_beats <= rd_beats + 1'b1;
      if (wr_fire) wr_beats <= wr_beats + 1'b1;
    end
  end
endmodule

// File: tb/tb_host_mem_responder.sv
// tb_host_mem_responder: directed checks of read/write bursts, range errors, priority and reset abort.
module tb_host_mem_responder;
  logic clk = 0, reset = 1;
  logic read_enable = 0, finish_read = 0, write_enable = 0, finish_write = 0, dbg_we = 0;
  logic [63:0] read_addr = 0, read_size = 4, write_addr = 0, write_size = 4;
  logic [31:0] write_data = 0, dbg_wdata = 0;
  logic [12:0] dbg_addr = 0;
  logic [63:0] read_ready, write_ready;
  logic [31:0] read_data, dbg_rdata, rd_beats, wr_beats;
  logic err;
  int errors = 0, checks = 0, cyc = 0, rr_cnt = 0;
  logic [31:0] d;
  int t, t_prev;

  host_mem_responder dut (
    .clk(clk), .reset(reset),
    .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size), .finish_read(finish_read),
    .read_ready(read_ready), .read_data(read_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data), .write_size(write_size),
    .finish_write(finish_write), .write_ready(write_ready),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
    .err(err), .rd_beats(rd_beats), .wr_beats(wr_beats)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (read_ready[0]) rr_cnt <= rr_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic dbg_wr(input logic [12:0] a, input logic [31:0] v);
    dbg_addr = a; dbg_wdata = v; dbg_we = 1;
    @(negedge clk); dbg_we = 0;
  endtask

  task automatic dbg_rd(input logic [12:0] a, output logic [31:0] v);
    dbg_addr = a;
    @(negedge clk); v = dbg_rdata;
  endtask

  task automatic rd_beat(input logic [63:0] a, input bit first, output logic [31:0] v, output int tt);
    read_addr = a;
    if (first) read_enable = 1; else finish_read = 1;
    @(negedge clk); finish_read = 0;
    for (int i = 0; i < 16 && !read_ready[0]; i++) @(negedge clk);
    if (!read_ready[0]) check("rd_timeout", 0, 1);
    v = read_data; tt = cyc;
    @(negedge clk);
  endtask

  task automatic wr_beat(input logic [63:0] a, input logic [31:0] v, input bit first);
    write_addr = a; write_data = v;
    if (first) write_enable = 1; else finish_write = 1;
    @(negedge clk); finish_write = 0;
    for (int i = 0; i < 16 && !write_ready[0]; i++) @(negedge clk);
    if (!write_ready[0]) check("wr_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int base_rr;
    repeat (2) @(negedge clk);
    check("rst_read_ready", read_ready, 0);
    check("rst_write_ready", write_ready, 0);
    check("rst_read_data", read_data, 0);
    check("rst_err", err, 0);
    check("rst_rd_beats", rd_beats, 0);
    check("rst_wr_beats", wr_beats, 0);
    reset = 0;
    @(negedge clk);
    // T1
    for (int i = 0; i < 4; i++) dbg_wr(13'(i), 32'(10 + i));
    for (int i = 0; i < 4; i++) begin
      rd_beat(64'(4 * i), i == 0, d, t);
      check($sformatf("t1_data%0d", i), d, 32'(10 + i));
      if (i > 0) check($sformatf("t1_space%0d", i), t - t_prev, 4);
      t_prev = t;
    end
    read_enable = 0;
    @(negedge clk);
    check("t1_rd_beats", rd_beats, 4);
    check("t1_read_data_hold", read_data, 13);
    // T2
    wr_beat(8, 7, 1);
    wr_beat(12, 9, 0);
    write_enable = 0;
    @(negedge clk);
    dbg_rd(2, d); check("t2_word2", d, 7);
    dbg_rd(3, d); check("t2_word3", d, 9);
    check("t2_wr_beats", wr_beats, 2);
    check("t2_err", err, 0);
    // T3
    rd_beat(64'd32768, 1, d, t);
    check("t3_oor_data", d, 32'hDEADBEEF);
    check("t3_err_a", err, 1);
    rd_beat(64'd6, 0, d, t);
    check("t3_mis_data", d, 32'hDEADBEEF);
    read_enable = 0;
    repeat (3) @(negedge clk);
    check("t3_err_sticky", err, 1);
    check("t3_rd_beats", rd_beats, 6);
    // T4
    base_rr = rr_cnt;
    read_addr = 16; read_enable = 1;
    wr_beat(16, 32'h55, 1);
    repeat (2) @(negedge clk);
    check("t4_no_read_during_write", rr_cnt, base_rr);
    check("t4_wr_beats", wr_beats, 3);
    write_enable = 0;
    rd_beat(16, 1, d, t);
    check("t4_read_after_write", d, 32'h55);
    read_enable = 0;
    @(negedge clk);
    check("t4_rd_beats", rd_beats, 7);
    // T5
    base_rr = rr_cnt;
    read_addr = 0; read_enable = 1;
    @(negedge clk); read_enable = 0;
    repeat (4) @(negedge clk);
    check("t5_no_pulse", rr_cnt, base_rr);
    check("t5_rd_beats", rd_beats, 7);
    rd_beat(4, 1, d, t);
    check("t5_fresh_read", d, 11);
    read_enable = 0;
    @(negedge clk);
    // T6
    write_addr = 4; write_data = 5; write_enable = 1;
    @(negedge clk); reset = 1;
    @(negedge clk);
    check("t6_write_ready", write_ready, 0);
    check("t6_read_data", read_data, 0);
    check("t6_rd_beats", rd_beats, 0);
    check("t6_wr_beats", wr_beats, 0);
    check("t6_err", err, 0);
    check("t6_dbg_rdata", dbg_rdata, 0);
    write_enable = 0; reset = 0;
    @(negedge clk);
    dbg_rd(1, d); check("t6_word1_kept", d, 11);
    wr_beat(20, 32'h77, 1);
    write_enable = 0;
    @(negedge clk);
    check("t6_wr_beats_after", wr_beats, 1);
    dbg_rd(5, d); check("t6_word5", d, 32'h77);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
